// File: rtl/switch_pkg.sv
// Shared types for the wormhole switch allocator: index widths for the default
// 5x5 configuration and the per-output allocation state.
package switch_pkg;

    localparam int DEF_NUM_IN  = 5;
    localparam int DEF_NUM_OUT = 5;

    typedef logic [$clog2(DEF_NUM_IN)-1:0]  in_idx_t;
    typedef logic [$clog2(DEF_NUM_OUT)-1:0] out_idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } alloc_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// wrapping around N. Pointer management belongs to the caller.
module rr_arbiter #(
    parameter int N = 5
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic                 valid
);

    localparam int PW = $clog2(N);

    logic          found;
    int            pos;
    logic [PW-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        pos   = 0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            pos = (int'(ptr) + k) % N;
            idx = pos[PW-1:0];
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/switch_allocator.sv
// Per-output wormhole allocator: each idle output grants one requesting input by
// round-robin and holds the crossbar connection until that input's tail flit is sent.
module switch_allocator
    import switch_pkg::*;
#(
    parameter int NUM_IN  = DEF_NUM_IN,
    parameter int NUM_OUT = DEF_NUM_OUT
) (
    input  logic                                 clk,
    input  logic                                 n_rst,
    input  logic [NUM_IN-1:0]                    req_valid,
    input  logic [NUM_IN*$clog2(NUM_OUT)-1:0]    req_port,
    input  logic [NUM_IN-1:0]                    in_tail,
    input  logic [NUM_OUT-1:0]                   packet_sent,
    output logic [NUM_OUT*$clog2(NUM_IN)-1:0]    sel,
    output logic [NUM_OUT-1:0]                   enable,
    output logic [NUM_IN-1:0]                    in_locked,
    output logic [NUM_OUT-1:0]                   state_dbg
);

    localparam int IDXW_IN  = $clog2(NUM_IN);
    localparam int IDXW_OUT = $clog2(NUM_OUT);

    // Handshake: req_valid/req_port are level requests held by the input until it
    // sees itself locked; packet_sent[o] is a per-flit accept from the crossbar and
    // only releases the output when it coincides with the bound input's tail flag.

    alloc_state_e       state_q [NUM_OUT];
    alloc_state_e       state_d [NUM_OUT];
    logic [IDXW_IN-1:0] sel_q   [NUM_OUT];
    logic [IDXW_IN-1:0] sel_d   [NUM_OUT];
    logic [IDXW_IN-1:0] rr_q    [NUM_OUT];
    logic [IDXW_IN-1:0] rr_d    [NUM_OUT];
    logic [NUM_IN-1:0]  cand    [NUM_OUT];
    logic [NUM_IN-1:0]  gnt     [NUM_OUT];
    logic [NUM_OUT-1:0] arb_valid;

    function automatic logic [IDXW_IN-1:0] onehot_idx(input logic [NUM_IN-1:0] oh);
        logic [IDXW_IN-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (oh[i]) r = IDXW_IN'(i);
        end
        return r;
    endfunction

    function automatic logic [IDXW_IN-1:0] wrap_inc(input logic [IDXW_IN-1:0] v);
        if (int'(v) >= NUM_IN - 1) return '0;
        return v + IDXW_IN'(1);
    endfunction

    // Locked inputs are masked out so a bound input is never offered to a second output.
    for (genvar o = 0; o < NUM_OUT; o++) begin : g_out
        for (genvar i = 0; i < NUM_IN; i++) begin : g_cand
            assign cand[o][i] = req_valid[i]
                             && (req_port[i*IDXW_OUT +: IDXW_OUT] == IDXW_OUT'(o))
                             && !in_locked[i];
        end

        rr_arbiter #(.N(NUM_IN)) u_arb (
            .req   (cand[o]),
            .ptr   (rr_q[o]),
            .gnt   (gnt[o]),
            .valid (arb_valid[o])
        );
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int o = 0; o < NUM_OUT; o++) begin
                state_q[o] <= IDLE;
                sel_q[o]   <= '0;
                rr_q[o]    <= '0;
            end
        end else begin
            for (int o = 0; o < NUM_OUT; o++) begin
                state_q[o] <= state_d[o];
                sel_q[o]   <= sel_d[o];
                rr_q[o]    <= rr_d[o];
            end
        end
    end

    // The pointer moves only on release, so fairness is counted in packets, not flits.
    always_comb begin
        for (int o = 0; o < NUM_OUT; o++) begin
            state_d[o] = state_q[o];
            sel_d[o]   = sel_q[o];
            rr_d[o]    = rr_q[o];
            case (state_q[o])
                IDLE: begin
                    if (arb_valid[o]) begin
                        state_d[o] = BUSY;
                        sel_d[o]   = onehot_idx(gnt[o]);
                    end
                end
                BUSY: begin
                    if (packet_sent[o] && in_tail[sel_q[o]]) begin
                        state_d[o] = IDLE;
                        rr_d[o]    = wrap_inc(sel_q[o]);
                    end
                end
                default: state_d[o] = IDLE;
            endcase
        end
    end

    always_comb begin
        enable    = '0;
        sel       = '0;
        in_locked = '0;
        state_dbg = '0;
        for (int o = 0; o < NUM_OUT; o++) begin
            enable[o]                    = (state_q[o] == BUSY);
            state_dbg[o]                 = (state_q[o] == BUSY);
            sel[o*IDXW_IN +: IDXW_IN]    = sel_q[o];
            for (int i = 0; i < NUM_IN; i++) begin
                if (state_q[o] == BUSY && sel_q[o] == IDXW_IN'(i)) in_locked[i] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: directed scenarios plus random traffic, all checked
// cycle by cycle against a packet-level reference model.
module tb_switch_allocator;

    localparam int NI = 5;
    localparam int NO = 5;
    localparam int WI = 3;
    localparam int WO = 3;

    logic              clk = 1'b0;
    logic              n_rst;
    logic [NI-1:0]     req_valid;
    logic [NI*WO-1:0]  req_port;
    logic [NI-1:0]     in_tail;
    logic [NO-1:0]     packet_sent;
    logic [NO*WI-1:0]  sel;
    logic [NO-1:0]     enable;
    logic [NI-1:0]     in_locked;
    logic [NO-1:0]     state_dbg;

    int checks   = 0;
    int failures = 0;

    // Reference model: per output, whether a packet is in flight, its owner, and the
    // round-robin start point.
    int m_busy  [NO];
    int m_owner [NO];
    int m_ptr   [NO];

    logic [NO-1:0] prev_en;
    int            prev_sel [NO];
    bit            rst_seen;

    switch_allocator #(.NUM_IN(NI), .NUM_OUT(NO)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .req_valid   (req_valid),
        .req_port    (req_port),
        .in_tail     (in_tail),
        .packet_sent (packet_sent),
        .sel         (sel),
        .enable      (enable),
        .in_locked   (in_locked),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int port_of(input int i);
        return int'(req_port[i*WO +: WO]);
    endfunction

    function automatic int sel_of(input int o);
        return int'(sel[o*WI +: WI]);
    endfunction

    function automatic bit m_locked(input int i);
        for (int o = 0; o < NO; o++) begin
            if (m_busy[o] != 0 && m_owner[o] == i) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic m_reset();
        for (int o = 0; o < NO; o++) begin
            m_busy[o]  = 0;
            m_owner[o] = 0;
            m_ptr[o]   = 0;
        end
    endtask

    task automatic model_step();
        int nb [NO];
        int nw [NO];
        int np [NO];
        if (!n_rst) begin
            m_reset();
            return;
        end
        for (int o = 0; o < NO; o++) begin
            nb[o] = m_busy[o];
            nw[o] = m_owner[o];
            np[o] = m_ptr[o];
            if (m_busy[o] != 0) begin
                if (packet_sent[o] && in_tail[m_owner[o]]) begin
                    nb[o] = 0;
                    np[o] = (m_owner[o] + 1) % NI;
                end
            end else begin
                for (int k = 0; k < NI; k++) begin
                    int i = (m_ptr[o] + k) % NI;
                    if (req_valid[i] && port_of(i) == o && !m_locked(i)) begin
                        nb[o] = 1;
                        nw[o] = i;
                        break;
                    end
                end
            end
        end
        for (int o = 0; o < NO; o++) begin
            m_busy[o]  = nb[o];
            m_owner[o] = nw[o];
            m_ptr[o]   = np[o];
        end
    endtask

    task automatic compare_all();
        logic [NO-1:0]    m_en;
        logic [NO*WI-1:0] m_sel;
        logic [NI-1:0]    m_lk;
        logic [NI-1:0]    lk_dut;
        int               max_bind;
        m_en  = '0;
        m_sel = '0;
        m_lk  = '0;
        for (int o = 0; o < NO; o++) begin
            m_en[o]            = (m_busy[o] != 0);
            m_sel[o*WI +: WI]  = 3'(m_owner[o]);
        end
        for (int i = 0; i < NI; i++) m_lk[i] = m_locked(i);
        check("enable", 32'(enable), 32'(m_en));
        check("sel", 32'(sel), 32'(m_sel));
        check("in_locked", 32'(in_locked), 32'(m_lk));
        check("state_dbg", 32'(state_dbg), 32'(m_en));

        lk_dut   = '0;
        max_bind = 0;
        for (int i = 0; i < NI; i++) begin
            int cnt = 0;
            for (int o = 0; o < NO; o++) begin
                if (enable[o] && sel_of(o) == i) cnt++;
            end
            if (cnt > 0) lk_dut[i] = 1'b1;
            if (cnt > max_bind) max_bind = cnt;
        end
        check("lock_or", 32'(in_locked), 32'(lk_dut));
        check("one_bind", 32'(max_bind <= 1), 32'd1);
        for (int o = 0; o < NO; o++) begin
            if (prev_en[o] && !enable[o] && !rst_seen)
                check("en_fall", 32'(packet_sent[o] && in_tail[prev_sel[o]]), 32'd1);
        end
        prev_en = enable;
        for (int o = 0; o < NO; o++) prev_sel[o] = sel_of(o);
        rst_seen = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_req(input int i, input int p);
        req_valid[i]         = 1'b1;
        req_port[i*WO +: WO] = 3'(p);
    endtask

    task automatic clear_all();
        req_valid   = '0;
        req_port    = '0;
        in_tail     = '0;
        packet_sent = '0;
    endtask

    task automatic apply_reset_now();
        n_rst    = 1'b0;
        rst_seen = 1'b1;
        m_reset();
    endtask

    initial begin
        int order [4];
        int gcyc  [4];
        int ng;

        n_rst    = 1'b0;
        rst_seen = 1'b1;
        prev_en  = '0;
        for (int o = 0; o < NO; o++) prev_sel[o] = 0;
        clear_all();
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_enable", 32'(enable), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_locked", 32'(in_locked), 32'd0);
        n_rst = 1'b1;

        // Single request: input 2 -> output 3.
        set_req(2, 3);
        step();
        check("t1_en3", 32'(enable[3]), 32'd1);
        check("t1_sel3", 32'(sel_of(3)), 32'd2);
        check("t1_lock", 32'(in_locked), 32'b00100);
        req_valid      = '0;
        in_tail[2]     = 1'b1;
        packet_sent[3] = 1'b1;
        step();
        check("t1_release", 32'(enable), 32'd0);
        clear_all();
        step();

        // Three inputs contend for output 1 with single-flit packets.
        set_req(0, 1);
        set_req(1, 1);
        set_req(4, 1);
        in_tail = '1;
        ng = 0;
        for (int c = 0; c < 20 && ng < 4; c++) begin
            if (enable[1]) begin
                order[ng] = sel_of(1);
                gcyc[ng]  = c;
                ng++;
                packet_sent = 5'b00010;
            end else begin
                packet_sent = '0;
            end
            step();
        end
        check("t2_grants", 32'(ng), 32'd4);
        if (ng == 4) begin
            check("t2_order0", 32'(order[0]), 32'd0);
            check("t2_order1", 32'(order[1]), 32'd1);
            check("t2_order2", 32'(order[2]), 32'd4);
            check("t2_order3", 32'(order[3]), 32'd0);
            for (int k = 1; k < 4; k++) check("t2_gap", 32'(gcyc[k] - gcyc[k-1]), 32'd2);
        end
        clear_all();
        step();

        // Four-flit packet from input 3 on output 0 with a request bubble and a contender.
        set_req(3, 0);
        step();
        check("t3_sel0", 32'(sel_of(0)), 32'd3);
        set_req(1, 0);
        packet_sent[0] = 1'b1;
        step();
        step();
        packet_sent[0] = 1'b0;
        req_valid[3]   = 1'b0;
        step();
        step();
        check("t3_hold_en", 32'(enable[0]), 32'd1);
        check("t3_hold_sel", 32'(sel_of(0)), 32'd3);
        req_valid[3]   = 1'b1;
        packet_sent[0] = 1'b1;
        step();
        in_tail[3] = 1'b1;
        step();
        check("t3_tail_off", 32'(enable[0]), 32'd0);
        packet_sent  = '0;
        in_tail      = '0;
        req_valid[3] = 1'b0;
        step();
        check("t3_regrant_en", 32'(enable[0]), 32'd1);
        check("t3_regrant_sel", 32'(sel_of(0)), 32'd1);
        req_valid[1]   = 1'b0;
        in_tail[1]     = 1'b1;
        packet_sent[0] = 1'b1;
        step();
        clear_all();
        step();

        // Two independent connections granted together, released separately.
        set_req(0, 2);
        set_req(1, 4);
        step();
        check("t4_both", 32'(enable & 5'b10100), 32'b10100);
        req_valid[0]   = 1'b0;
        in_tail[0]     = 1'b1;
        packet_sent[2] = 1'b1;
        step();
        check("t4_en2_off", 32'(enable[2]), 32'd0);
        check("t4_en4_kept", 32'(enable[4]), 32'd1);
        check("t4_sel4_kept", 32'(sel_of(4)), 32'd1);
        clear_all();
        in_tail[1]     = 1'b1;
        packet_sent[4] = 1'b1;
        step();
        clear_all();
        step();

        // Idle-output packet_sent and an out-of-range port never produce a grant.
        set_req(2, 7);
        for (int c = 0; c < 4; c++) begin
            packet_sent[0] = (c % 2 == 0);
            step();
            check("t5_no_enable", 32'(enable), 32'd0);
        end
        clear_all();
        step();

        // Reset mid-packet; the pending contender is re-granted from pointer 0.
        set_req(3, 0);
        step();
        check("t6_sel0", 32'(sel_of(0)), 32'd3);
        set_req(1, 0);
        packet_sent[0] = 1'b1;
        step();
        apply_reset_now();
        #1;
        check("t6_rst_en", 32'(enable), 32'd0);
        check("t6_rst_lock", 32'(in_locked), 32'd0);
        check("t6_rst_sel", 32'(sel), 32'd0);
        packet_sent = '0;
        step();
        n_rst = 1'b1;
        step();
        check("t6_regrant_sel", 32'(sel_of(0)), 32'd1);
        check("t6_regrant_en", 32'(enable[0]), 32'd1);
        clear_all();

        // Random traffic with occasional asynchronous resets.
        for (int c = 0; c < 3000; c++) begin
            n_rst       = 1'b1;
            req_valid   = 5'($urandom_range(0, 31));
            req_port    = 15'($urandom);
            in_tail     = 5'($urandom) & 5'($urandom);
            packet_sent = 5'($urandom);
            if ($urandom_range(0, 399) == 0) apply_reset_now();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
